// File: rtl/vga_frame_timer.sv
// Free-running VGA raster timing source: pixel coordinates, sync pulses,
// display enable, line/frame strobes and a frame counter, all registered.
module vga_frame_timer #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int FRAME_BITS = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [9:0]            hpos,
    output logic [9:0]            vpos,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  display_on,
    output logic                  line_start,
    output logic                  frame_start,
    output logic [FRAME_BITS-1:0] frame_no
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    // Coordinates are 10 bits wide, so both totals must fit in 1024.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 ||
        H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_param_err
        $error("vga_frame_timer: illegal timing parameters");
    end

    logic [9:0]            hpos_q, hpos_d;
    logic [9:0]            vpos_q, vpos_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  disp_q, disp_d;
    logic                  line_q, line_d;
    logic                  frame_q, frame_d;
    logic [FRAME_BITS-1:0] fno_q, fno_d;

    // Next raster position and the outputs that describe it.
    always_comb begin
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        if (hpos_q == H_LAST) begin
            hpos_d = 10'd0;
            if (vpos_q == V_LAST) begin
                vpos_d = 10'd0;
            end else begin
                vpos_d = vpos_q + 10'd1;
            end
        end else begin
            hpos_d = hpos_q + 10'd1;
        end

        hsync_d = (hpos_d >= HS_START && hpos_d < HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d = (vpos_d >= VS_START && vpos_d < VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
        disp_d  = (hpos_d < H_VIS) && (vpos_d < V_VIS);
        line_d  = (hpos_d == 10'd0);
        frame_d = (hpos_d == 10'd0) && (vpos_d == 10'd0);

        if (hpos_d == 10'd0 && vpos_d == VS_START) begin
            fno_d = fno_q + FRAME_BITS'(1);
        end else begin
            fno_d = fno_q;
        end
    end

    // State and output registers; reset parks just before (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            hpos_q  <= H_LAST;
            vpos_q  <= V_LAST;
            hsync_q <= ~H_SYNC_POL;
            vsync_q <= ~V_SYNC_POL;
            disp_q  <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            fno_q   <= '0;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            disp_q  <= disp_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            fno_q   <= fno_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = disp_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign frame_no    = fno_q;

endmodule

// File: tb/tb_vga_frame_timer.sv
// Randomised-reset bench for vga_frame_timer: a default 640x480 instance and a
// tiny instance (2-bit frame counter, active-high syncs) against an arithmetic raster model.
module tb_vga_frame_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos;
    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [8:0] d_fn;
    logic [1:0] s_fn;

    vga_frame_timer u_def (
        .clk(clk), .rst(rst), .hpos(d_hpos), .vpos(d_vpos), .hsync(d_hs),
        .vsync(d_vs), .display_on(d_de), .line_start(d_ls),
        .frame_start(d_fs), .frame_no(d_fn)
    );

    vga_frame_timer #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .FRAME_BITS(2)
    ) u_small (
        .clk(clk), .rst(rst), .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hs),
        .vsync(s_vs), .display_on(s_de), .line_start(s_ls),
        .frame_start(s_fs), .frame_no(s_fn)
    );

    typedef struct packed {
        logic [9:0]  hpos;
        logic [9:0]  vpos;
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
        logic [15:0] fn;
    } exp_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    in_rst   = 1'b1;
    longint t_cyc   = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0d, want %0d", tag, t_cyc, obs, exp);
        end
    endtask

    // Expected outputs from elapsed cycles since reset release.
    function automatic exp_t model(input int hd, hf, hsw, hb, vd, vf, vsw, vb,
                                   input bit hp, vp, input int fbits,
                                   input bit inr, input longint t);
        exp_t   e;
        longint ht, vt, ft, p, h, v, off, n;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        ft = ht * vt;
        if (inr) begin
            e.hpos = 10'(ht - 1); e.vpos = 10'(vt - 1);
            e.hs = ~hp; e.vs = ~vp;
            e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.fn = 16'd0;
        end else begin
            p = t % ft;
            h = p % ht;
            v = p / ht;
            e.hpos = 10'(h); e.vpos = 10'(v);
            e.hs = (h >= hd + hf && h < hd + hf + hsw) ? hp : ~hp;
            e.vs = (v >= vd + vf && v < vd + vf + vsw) ? vp : ~vp;
            e.de = (h < hd) && (v < vd);
            e.ls = (h == 0);
            e.fs = (p == 0);
            off = (vd + vf) * ht;
            n = (t >= off) ? (t - off) / ft + 1 : 0;
            e.fn = 16'(n % (64'd1 << fbits));
        end
        return e;
    endfunction

    task automatic step();
        exp_t e;
        @(posedge clk);
        if (rst) begin
            in_rst = 1'b1;
        end else if (in_rst) begin
            in_rst = 1'b0;
            t_cyc  = 0;
        end else begin
            t_cyc++;
        end
        #1;
        e = model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 9, in_rst, t_cyc);
        check_val("def_hpos",  int'(d_hpos), int'(e.hpos));
        check_val("def_vpos",  int'(d_vpos), int'(e.vpos));
        check_val("def_hsync", int'(d_hs),   int'(e.hs));
        check_val("def_vsync", int'(d_vs),   int'(e.vs));
        check_val("def_disp",  int'(d_de),   int'(e.de));
        check_val("def_line",  int'(d_ls),   int'(e.ls));
        check_val("def_frame", int'(d_fs),   int'(e.fs));
        check_val("def_fno",   int'(d_fn),   int'(e.fn));
        e = model(8, 2, 3, 2, 6, 2, 2, 3, 1'b1, 1'b1, 2, in_rst, t_cyc);
        check_val("sm_hpos",  int'(s_hpos), int'(e.hpos));
        check_val("sm_vpos",  int'(s_vpos), int'(e.vpos));
        check_val("sm_hsync", int'(s_hs),   int'(e.hs));
        check_val("sm_vsync", int'(s_vs),   int'(e.vs));
        check_val("sm_disp",  int'(s_de),   int'(e.de));
        check_val("sm_line",  int'(s_ls),   int'(e.ls));
        check_val("sm_frame", int'(s_fs),   int'(e.fs));
        check_val("sm_fno",   int'(s_fn),   int'(e.fn));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        // Long run: many small-instance frames (counter wrap), default lines 0..~24.
        repeat (20000) step();
        for (int i = 0; i < 15; i++) begin
            int run_len;
            int rst_len;
            run_len = int'($urandom_range(1, 2000));
            rst_len = int'($urandom_range(1, 3));
            repeat (run_len) step();
            rst = 1'b1;
            repeat (rst_len) step();
            rst = 1'b0;
        end
        repeat (2000) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
